// File: rtl/dsp_arb.sv
// Purpose: arbitrates two requesters onto one DSP slice and returns results with their owner's id.
// Latency: accept at edge E0 -> rsp_valid after unstalled edge E0+LAT+1; one result per cycle when back-to-back.
// Backpressure: stall freezes accepts, tag pipe, pointer and dsp_ce. Macro DSP_ARB_STRICT_PRIO_EN selects strict req0 priority.
module dsp_arb #(
    parameter int LAT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [17:0] req0_a,
    input  logic [17:0] req0_b,
    input  logic [17:0] req0_d,
    input  logic [47:0] req0_c,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [17:0] req1_a,
    input  logic [17:0] req1_b,
    input  logic [17:0] req1_d,
    input  logic [47:0] req1_c,
    input  logic        stall,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [47:0] dsp_c,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    input  logic [47:0] dsp_p,
    output logic [1:0]  rsp_valid,
    output logic [47:0] rsp_p,
    output logic        busy
);

    logic         gnt0;
    logic         gnt1;
    logic         accept;
    logic         acc_id;
    logic [1:0]   sel_op;
    logic [7:0]   sel_opmode;
    logic [LAT:0] tag_vld;
    logic [LAT:0] tag_id;

`ifdef DSP_ARB_STRICT_PRIO_EN
    // req0 always wins when it is valid; no fairness state is kept
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
    end
`else
    logic last_gnt;  // id of the requester granted most recently

    // round-robin: on contention the requester not granted last time wins
    always_comb begin
        gnt0 = req0_valid & (~req1_valid | last_gnt);
        gnt1 = req1_valid & ~gnt0;
    end

    // pointer starts at 1 so req0 wins the first contention; frozen while stalled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            last_gnt <= 1'b1;
        else if (accept)
            last_gnt <= acc_id;
    end
`endif

    // ready is the grant qualified by stall; held low during reset
    always_comb begin
        req0_ready = gnt0 & ~stall & ~RST;
        req1_ready = gnt1 & ~stall & ~RST;
        accept     = req0_ready | req1_ready;
        acc_id     = req1_ready;
        dsp_ce     = ~stall & ~RST;
        busy       = |tag_vld;
    end

    // translate the selected requester's op code into the DSP OPMODE
    always_comb begin
        sel_op     = acc_id ? req1_op : req0_op;
        sel_opmode = 8'h01;
        case (sel_op)
            2'b00: sel_opmode = 8'h01;  // A*B
            2'b01: sel_opmode = 8'h11;  // (D+B)*A
            2'b10: sel_opmode = 8'h0D;  // A*B+C
            2'b11: sel_opmode = 8'h5D;  // (D-B)*A+C
            default: sel_opmode = 8'h01;
        endcase
    end

    // operand registers feeding the DSP load only on accept, otherwise hold
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_d      <= '0;
            dsp_c      <= '0;
            dsp_opmode <= '0;
        end else if (accept) begin
            dsp_a      <= acc_id ? req1_a : req0_a;
            dsp_b      <= acc_id ? req1_b : req0_b;
            dsp_d      <= acc_id ? req1_d : req0_d;
            dsp_c      <= acc_id ? req1_c : req0_c;
            dsp_opmode <= sel_opmode;
        end
    end

    // tag pipe mirrors the DSP pipeline depth plus the operand register stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else if (!stall) begin
            tag_vld <= {tag_vld[LAT-1:0], accept};
            tag_id  <= {tag_id[LAT-1:0], acc_id};
        end
    end

    // capture dsp_p as the tag leaves the last stage; strobe is one cycle wide
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid <= '0;
            rsp_p     <= '0;
        end else if (stall) begin
            rsp_valid <= '0;
        end else begin
            rsp_valid <= tag_vld[LAT] ? (tag_id[LAT] ? 2'b10 : 2'b01) : 2'b00;
            if (tag_vld[LAT])
                rsp_p <= dsp_p;
        end
    end

endmodule

// File: tb/tb_dsp_arb.sv
// Purpose: randomized and directed stimulus for dsp_arb with a DSP slice model and a response scoreboard.
// Latency: expected responses are timed in unstalled clock edges after the accepting edge.
// Backpressure: stall is driven both in directed windows and randomly.
module tb_dsp_arb;
    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [17:0] req0_a, req0_b, req0_d, req1_a, req1_b, req1_d;
    logic [47:0] req0_c, req1_c;
    logic        stall;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce;
    logic [47:0] dsp_p;
    logic [1:0]  rsp_valid;
    logic [47:0] rsp_p;
    logic        busy;

    dsp_arb #(.LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_d(req0_d), .req0_c(req0_c),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_d(req1_d), .req1_c(req1_c),
        .stall(stall),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_p(dsp_p),
        .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          id;
        logic [47:0] p;
        int          due;   // unstalled-edge count after which the strobe is visible
    } exp_t;

    exp_t        scb[$];
    int          tests = 0;
    int          fails = 0;
    int          ue = 0;          // unstalled, out-of-reset edges seen so far
    bit          last_m = 1'b1;   // requester granted most recently (model)
    logic [47:0] dpipe [LAT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] calc(input logic [1:0] op, input logic [17:0] a,
                                         input logic [17:0] b, input logic [17:0] d,
                                         input logic [47:0] c);
        logic signed [47:0] sa, sbv, sd, sc, r;
        sa  = {{30{a[17]}}, a};
        sbv = {{30{b[17]}}, b};
        sd  = {{30{d[17]}}, d};
        sc  = c;
        case (op)
            2'd0:    r = sa * sbv;
            2'd1:    r = (sd + sbv) * sa;
            2'd2:    r = sa * sbv + sc;
            default: r = (sd - sbv) * sa + sc;
        endcase
        return r;
    endfunction

    // behavioural DSP slice: decode OPMODE, LAT register stages gated by dsp_ce
    function automatic logic [47:0] dsp_fn(input logic [7:0] m);
        case (m)
            8'h01:   return calc(2'd0, dsp_a, dsp_b, dsp_d, dsp_c);
            8'h11:   return calc(2'd1, dsp_a, dsp_b, dsp_d, dsp_c);
            8'h0D:   return calc(2'd2, dsp_a, dsp_b, dsp_d, dsp_c);
            8'h5D:   return calc(2'd3, dsp_a, dsp_b, dsp_d, dsp_c);
            default: return 48'h0BAD_0BAD_0BAD;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (dsp_ce) begin
            dpipe[0] <= dsp_fn(dsp_opmode);
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end
    assign dsp_p = dpipe[LAT-1];

    always @(posedge CLK) begin
        if (!RST && !stall) ue <= ue + 1;
    end

    // monitor: compares every cycle against the scoreboard head
    always @(negedge CLK) begin
        int nb;
        if (RST) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_p", rsp_p, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ce", dsp_ce, 0);
            chk("rst_ready", {req1_ready, req0_ready}, 0);
            chk("rst_dsp_ops", {dsp_a, dsp_b, dsp_d}, 0);
            chk("rst_dsp_c_opm", {dsp_c, dsp_opmode}, 0);
        end else begin
            if (scb.size() > 0 && scb[0].due == ue) begin
                chk("rsp_valid", rsp_valid, (scb[0].id == 1) ? 2'b10 : 2'b01);
                chk("rsp_p", rsp_p, scb[0].p);
                void'(scb.pop_front());
            end else begin
                chk("rsp_idle", rsp_valid, 0);
            end
            nb = 0;
            foreach (scb[i]) if (scb[i].due - (LAT + 1) <= ue) nb++;
            chk("busy", busy, nb > 0);
        end
    end

    // check grant for the current inputs, then let the edge happen
    task automatic step();
        bit g0, g1;
        #1;
`ifdef DSP_ARB_STRICT_PRIO_EN
        g0 = req0_valid;
`else
        g0 = (req0_valid && req1_valid) ? last_m : req0_valid;
`endif
        g1 = req1_valid && !g0;
        chk("req0_ready", req0_ready, g0 && !stall);
        chk("req1_ready", req1_ready, g1 && !stall);
        chk("dsp_ce", dsp_ce, !stall);
        if (!stall && (g0 || g1)) begin
            exp_t e;
            e.id  = g1 ? 1 : 0;
            e.p   = g1 ? calc(req1_op, req1_a, req1_b, req1_d, req1_c)
                       : calc(req0_op, req0_a, req0_b, req0_d, req0_c);
            e.due = ue + LAT + 2;
            scb.push_back(e);
            last_m = g1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_ops();
        req0_op = 2'($urandom); req1_op = 2'($urandom);
        req0_a = 18'($urandom); req0_b = 18'($urandom); req0_d = 18'($urandom);
        req1_a = 18'($urandom); req1_b = 18'($urandom); req1_d = 18'($urandom);
        req0_c = {16'($urandom), 32'($urandom)};
        req1_c = {16'($urandom), 32'($urandom)};
    endtask

    task automatic idle(input int n, input bit st);
        req0_valid = 0; req1_valid = 0; stall = st;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        scb.delete();
        last_m = 1'b1;
        for (int i = 0; i < cycles; i++) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        req0_valid = 0; req1_valid = 0; stall = 0;
        rand_ops();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) @(posedge CLK);
        #1;
        RST = 1'b0;

        // req0 (D+B)*A = (3+5)*2 = 16
        req0_valid = 1; req0_op = 2'b01; req0_a = 18'd2; req0_d = 18'd3; req0_b = 18'd5; req0_c = 48'd0;
        step();
        idle(LAT + 3, 0);

        // req1 A*B+C = 5*9+8 = 53
        req1_valid = 1; req1_op = 2'b10; req1_a = 18'd5; req1_b = 18'd9; req1_c = 48'd8; req1_d = 18'd0;
        step();
        idle(LAT + 3, 0);

        // both valid for 4 cycles: alternating grants, back-to-back results
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            req0_valid = 1; req1_valid = 1; stall = 0;
            step();
        end
        idle(LAT + 3, 0);

        // accept, wait two cycles, stall three cycles with requests pending
        rand_ops();
        req0_valid = 1; req1_valid = 0;
        step();
        idle(2, 0);
        req0_valid = 1; req1_valid = 1; stall = 1;
        for (int i = 0; i < 3; i++) step();
        idle(LAT + 4, 0);

        // randomized traffic with random stall
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            req0_valid = ($urandom_range(0, 1) == 1);
            req1_valid = ($urandom_range(0, 1) == 1);
            stall      = ($urandom_range(0, 7) == 0);
            step();
        end
        idle(LAT + 4, 0);

        // reset with three operations in flight; none may come back
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            req0_valid = 1; req1_valid = ($urandom_range(0, 1) == 1); stall = 0;
            step();
        end
        req0_valid = 0; req1_valid = 0;
        do_reset(2);
        idle(LAT + 6, 0);

        // contention directly after reset: req0 must win first
        rand_ops();
        req0_valid = 1; req1_valid = 1; stall = 0;
        for (int i = 0; i < 3; i++) step();
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 50 && scb.size() > 0; i++) step();
        chk("drain", scb.size(), 0);
        chk("busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
